// File: rtl/wm8960_init_seq.sv
// WM8960 power-up register sequencer.
// Walks the init table and issues one two-byte I2C write per entry.
module wm8960_init_seq #(
    parameter int PWRUP_CYCLES      = 500000,
    parameter int RESET_WAIT_CYCLES = 50000,
    parameter int GAP_CYCLES        = 100,
    parameter int MAX_RETRY         = 3,
    parameter int AUTO_START        = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_q,
    input  logic [7:0]  dev_id,
    input  logic [7:0]  lut_size,
    output logic        i2c_req,
    output logic [7:0]  i2c_dev,
    output logic [7:0]  i2c_byte_hi,
    output logic [7:0]  i2c_byte_lo,
    input  logic        i2c_done,
    input  logic        i2c_ack_err,
    output logic        busy,
    output logic        init_done,
    output logic        init_err,
    output logic [7:0]  err_index
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PWRUP,
        S_FETCH,
        S_REQ,
        S_WAIT,
        S_SETTLE,
        S_DONE,
        S_FAIL
    } state_t;

    // Counter reload values: a load of N-1 gives exactly N cycles in state.
    localparam logic [19:0] PWRUP_LD =
        (PWRUP_CYCLES > 0) ? 20'(PWRUP_CYCLES - 1) : 20'd0;
    localparam logic [19:0] RST_LD =
        (RESET_WAIT_CYCLES > 0) ? 20'(RESET_WAIT_CYCLES - 1) : 20'd0;
    localparam logic [19:0] GAP_LD =
        (GAP_CYCLES > 0) ? 20'(GAP_CYCLES - 1) : 20'd0;
    localparam logic [7:0]  MAXR = 8'(MAX_RETRY);
    localparam logic [6:0]  REG_RESET = 7'h0F;

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [7:0]  idx_q, idx_d;
    logic        ph_q, ph_d;
    logic [7:0]  retry_q, retry_d;
    logic        req_q, req_d;
    logic [7:0]  dev_q, dev_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [7:0]  eidx_q, eidx_d;
    logic        go;
    logic [7:0]  idx_nx;

    // State and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 20'd0;
            idx_q   <= 8'd0;
            ph_q    <= 1'b0;
            retry_q <= 8'd0;
            req_q   <= 1'b0;
            dev_q   <= 8'd0;
            hi_q    <= 8'd0;
            lo_q    <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            eidx_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ph_q    <= ph_d;
            retry_q <= retry_d;
            req_q   <= req_d;
            dev_q   <= dev_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            eidx_q  <= eidx_d;
        end
    end

    // Next-state logic; status flags are derived from the next state
    // so they stay registered yet line up with the state register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ph_d    = ph_q;
        retry_d = retry_q;
        req_d   = req_q;
        dev_d   = dev_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        eidx_d  = eidx_q;
        idx_nx  = idx_q + 8'd1;
        go      = 1'b0;

        unique case (state_q)
            S_IDLE: go = (AUTO_START != 0) || start;
            S_DONE, S_FAIL: go = start;
            default: go = 1'b0;
        endcase

        unique case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (go) begin
                    state_d = S_PWRUP;
                    cnt_d   = PWRUP_LD;
                    eidx_d  = 8'd0;
                end
            end
            S_PWRUP: begin
                if (cnt_q == 20'd0) begin
                    if (lut_size == 8'd0) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = 8'd0;
                        ph_d    = 1'b0;
                        state_d = S_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q - 20'd1;
                end
            end
            S_FETCH: begin
                if (!ph_q) begin
                    ph_d = 1'b1;
                end else begin
                    hi_d    = rom_q[15:8];
                    lo_d    = rom_q[7:0];
                    dev_d   = dev_id;
                    retry_d = 8'd0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                req_d   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i2c_done) begin
                    req_d = 1'b0;
                    if (!i2c_ack_err) begin
                        state_d = S_SETTLE;
                        cnt_d   = (hi_q[7:1] == REG_RESET) ? RST_LD : GAP_LD;
                    end else if (retry_q < MAXR) begin
                        retry_d = retry_q + 8'd1;
                        state_d = S_REQ;
                    end else begin
                        eidx_d  = idx_q;
                        state_d = S_FAIL;
                    end
                end
            end
            S_SETTLE: begin
                if (cnt_q == 20'd0) begin
                    idx_d = idx_nx;
                    ph_d  = 1'b0;
                    if (idx_nx == lut_size) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q - 20'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = !((state_d == S_IDLE) || (state_d == S_DONE) ||
                   (state_d == S_FAIL));
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_FAIL);
    end

    assign rom_addr    = idx_q;
    assign i2c_req     = req_q;
    assign i2c_dev     = dev_q;
    assign i2c_byte_hi = hi_q;
    assign i2c_byte_lo = lo_q;
    assign busy        = busy_q;
    assign init_done   = done_q;
    assign init_err    = err_q;
    assign err_index   = eidx_q;

endmodule

// File: tb/tb_wm8960_init_seq.sv
// Bench for wm8960_init_seq: table and I2C slave models plus a
// scoreboard of expected writes and inter-request gaps.
module tb_wm8960_init_seq;

    localparam int PW = 20;
    localparam int RW = 30;
    localparam int GP = 5;
    localparam int MR = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_q = 16'd0;
    logic [7:0]  dev_id = 8'h34;
    logic [7:0]  lut_size = 8'd16;
    logic        i2c_req;
    logic [7:0]  i2c_dev;
    logic [7:0]  i2c_byte_hi;
    logic [7:0]  i2c_byte_lo;
    logic        i2c_done = 1'b0;
    logic        i2c_ack_err = 1'b0;
    logic        busy;
    logic        init_done;
    logic        init_err;
    logic [7:0]  err_index;

    wm8960_init_seq #(
        .PWRUP_CYCLES(PW),
        .RESET_WAIT_CYCLES(RW),
        .GAP_CYCLES(GP),
        .MAX_RETRY(MR),
        .AUTO_START(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .rom_addr(rom_addr),
        .rom_q(rom_q),
        .dev_id(dev_id),
        .lut_size(lut_size),
        .i2c_req(i2c_req),
        .i2c_dev(i2c_dev),
        .i2c_byte_hi(i2c_byte_hi),
        .i2c_byte_lo(i2c_byte_lo),
        .i2c_done(i2c_done),
        .i2c_ack_err(i2c_ack_err),
        .busy(busy),
        .init_done(init_done),
        .init_err(init_err),
        .err_index(err_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dev;
        logic [7:0] hi;
        logic [7:0] lo;
        int         gap;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] rom[256];
    int          nack_plan[256];
    int          nack_left[256];
    int          n_pass = 0;
    int          n_total = 0;
    int          nreq = 0;
    int          cyc = 0;
    int          last_fall = 0;
    bit          req_prev = 1'b0;
    int          lat = 0;
    bit          exp_fail;
    int          exp_eidx;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Table read port with one cycle of latency.
    always @(posedge clk) rom_q <= rom[rom_addr];

    always @(posedge clk) cyc <= cyc + 1;

    // I2C controller model: random latency, NACKs from the per-entry plan.
    always @(negedge clk) begin
        if (!rst_n) begin
            i2c_done    = 1'b0;
            i2c_ack_err = 1'b0;
            lat         = 0;
        end else if (i2c_done) begin
            i2c_done    = 1'b0;
            i2c_ack_err = 1'b0;
        end else if (i2c_req) begin
            if (lat == 0) begin
                i2c_done = 1'b1;
                if (nack_left[rom_addr] > 0) begin
                    i2c_ack_err = 1'b1;
                    nack_left[rom_addr]--;
                end
                lat = $urandom_range(0, 3);
            end else begin
                lat--;
            end
        end
    end

    // Monitor: every rising i2c_req is checked against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            req_prev = 1'b0;
        end else begin
            if (i2c_req && !req_prev) begin
                nreq++;
                if (expq.size() == 0) begin
                    chk("unexpected_req", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("i2c_dev", i2c_dev, e.dev);
                    chk("byte_hi", i2c_byte_hi, e.hi);
                    chk("byte_lo", i2c_byte_lo, e.lo);
                    if (e.gap >= 0) chk("req_gap", cyc - last_fall, e.gap);
                end
            end
            if (!i2c_req && req_prev) last_fall = cyc;
            req_prev = i2c_req;
        end
    end

    // Reference model: expected writes for one full table pass.
    task automatic build(input int size);
        int   prev_reg;
        bit   first;
        int   att;
        exp_t e;
        expq.delete();
        exp_fail = 1'b0;
        exp_eidx = 0;
        first    = 1'b1;
        prev_reg = 0;
        for (int i = 0; i < 256; i++) nack_left[i] = nack_plan[i];
        for (int k = 0; k < size; k++) begin
            att = (nack_plan[k] > MR) ? MR + 1 : nack_plan[k] + 1;
            for (int a = 0; a < att; a++) begin
                e.dev = dev_id;
                e.hi  = rom[k][15:8];
                e.lo  = rom[k][7:0];
                if (first) e.gap = -1;
                else if (a > 0) e.gap = 1;
                else if (prev_reg == 15) e.gap = RW + 3;
                else e.gap = GP + 3;
                first = 1'b0;
                expq.push_back(e);
            end
            if (nack_plan[k] > MR) begin
                exp_fail = 1'b1;
                exp_eidx = k;
                break;
            end
            prev_reg = int'(rom[k][15:9]);
        end
    endtask

    task automatic fill_table(input int size);
        int r;
        for (int i = 0; i < 256; i++) begin
            r = $urandom_range(0, 127);
            if (r == 15) r = 16;
            rom[i] = {7'(r), 9'($urandom_range(0, 511))};
            nack_plan[i] = 0;
        end
        if (size > 3) begin
            rom[0] = {7'h0F, 9'h000};
            rom[1] = {7'h19, 9'h0FC};
            rom[2] = {7'h1A, 9'h1E1};
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input bit poke);
        int n = 0;
        bit poked = 1'b0;
        do begin
            @(posedge clk);
            #1;
            n++;
            start = 1'b0;
            if (poke && !poked && i2c_req && rom_addr == 8'd4) begin
                start = 1'b1;
                poked = 1'b1;
            end
        end while ((n < 2 || !(init_done || init_err)) && n < 20000);
        start = 1'b0;
        chk("run_terminates", 32'(init_done || init_err), 1);
    endtask

    task automatic check_end(input string tag, input int reqs_before,
                             input int nexp);
        @(negedge clk);
        chk({tag, "_init_done"}, 32'(init_done), 32'(!exp_fail));
        chk({tag, "_init_err"}, 32'(init_err), 32'(exp_fail));
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_err_index"}, err_index, exp_fail ? exp_eidx : 0);
        chk({tag, "_req_count"}, nreq - reqs_before, nexp);
        chk({tag, "_queue_empty"}, expq.size(), 0);
    endtask

    task automatic req_latency(input int exp);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!i2c_req && n < 500);
        chk("first_req_latency", n, exp);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_i2c_req"}, 32'(i2c_req), 0);
        chk({tag, "_i2c_dev"}, i2c_dev, 0);
        chk({tag, "_byte_hi"}, i2c_byte_hi, 0);
        chk({tag, "_byte_lo"}, i2c_byte_lo, 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(init_done), 0);
        chk({tag, "_err"}, 32'(init_err), 0);
        chk({tag, "_err_index"}, err_index, 0);
    endtask

    initial begin
        int b;
        int ne;
        int n;
        int sz;

        // Reset values, then nominal 16-entry auto-started run.
        fill_table(16);
        lut_size = 8'd16;
        dev_id   = 8'h34;
        build(16);
        ne = expq.size();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        b = nreq;
        rst_n = 1'b1;
        req_latency(1 + PW + 3);
        wait_end(1'b1);
        check_end("nominal", b, ne);

        // Single NACK on entry 5 plus sparse random NACKs.
        fill_table(16);
        for (int i = 0; i < 16; i++)
            if ($urandom_range(0, 3) == 0) nack_plan[i] = 1;
        nack_plan[5] = 1;
        nack_plan[7] = 0;
        build(16);
        ne = expq.size();
        b = nreq;
        pulse_start();
        wait_end(1'b0);
        check_end("nack_once", b, ne);

        // Persistent NACK on entry 7 ends in FAIL.
        fill_table(16);
        nack_plan[7] = 100;
        build(16);
        ne = expq.size();
        b = nreq;
        pulse_start();
        wait_end(1'b0);
        check_end("nack_fail", b, ne);
        repeat (40) @(negedge clk);
        chk("fail_no_more_reqs", nreq - b, ne);
        chk("fail_err_hold", err_index, 7);

        // Rerun from FAIL with random size, device and retries.
        sz = $urandom_range(1, 24);
        fill_table(sz);
        for (int i = 0; i < sz; i++) nack_plan[i] = $urandom_range(0, MR);
        dev_id   = 8'($urandom_range(0, 255));
        lut_size = 8'(sz);
        build(sz);
        ne = expq.size();
        b = nreq;
        pulse_start();
        wait_end(1'b0);
        check_end("random", b, ne);

        // Empty table: no requests, done one cycle after power-up delay.
        lut_size = 8'd0;
        build(0);
        b = nreq;
        @(negedge clk);
        start = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) start = 1'b0;
        end while (!init_done && n < 500);
        chk("empty_done_latency", n, PW + 1);
        check_end("empty", b, 0);

        // Reset while entry 3 is on the bus; sequence restarts at 0.
        fill_table(16);
        dev_id   = 8'h34;
        lut_size = 8'd16;
        build(16);
        pulse_start();
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(i2c_req && rom_addr == 8'd3) && n < 5000);
        chk("reached_entry3", 32'(i2c_req && rom_addr == 8'd3), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        repeat (3) @(negedge clk);
        build(16);
        ne = expq.size();
        b = nreq;
        rst_n = 1'b1;
        req_latency(1 + PW + 3);
        wait_end(1'b0);
        check_end("after_reset", b, ne);

        // Largest table: indices 0..254.
        fill_table(255);
        lut_size = 8'd255;
        build(255);
        ne = expq.size();
        b = nreq;
        pulse_start();
        wait_end(1'b0);
        check_end("lut255", b, ne);
        chk("lut255_last_addr", rom_addr, 255);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
